float_mult_pipe: RTL and testbench
==================================

// Module: float_mult_pipe
// PURPOSE
// - Pipelined, parametrised minifloat multiplier; successor to the combinational 8-bit float multiplier in the TPU datapath.
// - Format: {sign, EXP_W exponent, MAN_W fraction}, hidden leading 1, no subnormals/inf/NaN.
// - Adds valid/ready flow control, round-to-nearest-even, saturation, and separate overflow/underflow flags.
// - Feeds the TPU MAC array accumulator.
// PARAMETERS
// - EXP_W    3  exponent field width
// - MAN_W    4  fraction field width; word W = 1+EXP_W+MAN_W (default 8)
// - BIAS     4  exponent bias; value = (-1)^s * 1.f * 2^(e-BIAS)
// - SAT_EN   1  1: overflow saturates to max magnitude; 0: overflow outputs 0
// - RND_EN   1  1: round-to-nearest-even; 0: truncate
// PORTS
// - clk        in   1  clock, rising edge
// - rst        in   1  synchronous reset, active-high
// - iValid     in   1  operand pair valid
// - oReady     out  1  block accepts operands this cycle
// - iNum1      in   W  operand A
// - iNum2      in   W  operand B
// - oValid     out  1  result valid
// - iReady     in   1  downstream accepts result
// - oNum       out  W  product
// - overflow   out  1  result exponent > 2^EXP_W-1; qualified by oValid
// - underflow  out  1  nonzero product, exponent < 0; qualified by oValid
// BEHAVIOUR
// - Reset: all stage valids, oValid, oNum, overflow and underflow = 0.
//   - Reset mid-operation drops all in-flight data.
// - Flow control: adv = ~oValid | iReady; oReady = adv.
//   - All three stages shift together when adv=1, else all hold.
//   - Transfer in on iValid&oReady; transfer out on oValid&iReady.
//   - Latency is exactly 3 cycles with no stall; throughput is 1 per cycle.
//   - oNum and flags stay stable while oValid&~iReady.
// - S1: register operands and flags.
//   - zero = (magnitude field == 0), so 0x00 and 0x80 are both zero.
//   - sign = s1^s2.
//   - esum = e1+e2-BIAS, signed, EXP_W+2 bits.
// - S2: product P = {1,f1}*{1,f2}, 2*MAN_W+2 bits, unsigned.
// - S3: normalise, round, pack.
//   - If P msb=1: frac = P[2M:M+1], guard = P[M], sticky = |P[M-1:0], e = esum+1.
//   - Else: frac = P[2M-1:M], guard = P[M-1], sticky = |P[M-2:0], e = esum.
//   - RNE: increment when guard & (sticky | frac lsb).
//   - Fraction carry-out: frac = 0, e = e+1; may cause overflow.
//   - Either operand zero: oNum = 0 (sign 0), no flags.
//   - e > 2^EXP_W-1: overflow=1; oNum = {sign, all ones} if SAT_EN, else 0.
//   - e < 0: underflow=1, oNum = 0.
//   - overflow and underflow are mutually exclusive.
// STRUCTURE
// - Shared package float_pkg:
//   - EXP_W/MAN_W/BIAS defaults, W function.
//   - Field-slice localparams.
//   - Round-mode constants.
// - One sub-module: float_round_norm, covering S3 normalise, round and pack (combinational).
//   - Reused later by float_add_pipe.
// - Mantissa multiply is inline; no sub-module.
// TESTING (defaults: E3M4, BIAS 4, SAT_EN=1, RND_EN=1)
// - 0x48*0x48 (1.5*1.5) -> 0x52 after 3 cycles, no flags.
// - 0xC8*0x40 -> 0xC8.
//   - 0x00*0x7F -> 0x00.
//   - 0x80*0xC8 -> 0x00.
// - 0x47*0x47: RND_EN=1 -> 0x51; RND_EN=0 -> 0x50.
// - 0x7F*0x7F: SAT_EN=1 -> 0x7F, overflow=1; SAT_EN=0 -> 0x00, overflow=1.
//   - 0xFF*0x7F (SAT_EN=1) -> 0xFF, overflow=1.
// - 0x01*0x01 -> 0x00, underflow=1.
// - Stream 6 pairs back-to-back; hold iReady=0 for cycles 4..8.
//   - oReady low while stalled, oNum stable.
//   - All 6 results arrive in order with no loss or duplicates.
//   - Assert rst mid-stream: oValid=0 next cycle, no stale result afterwards.

Source files
------------

// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : float_pkg
//  Description : Shared definitions for the minifloat datapath blocks.
//                Contains the default format (E3M4, bias 4), the word-width
//                helper, field-slice positions of the default word and the
//                rounding/saturation mode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package float_pkg;

    // Default format: {sign, EXP_W exponent, MAN_W fraction}
    localparam int DEF_EXP_W = 3;
    localparam int DEF_MAN_W = 4;
    localparam int DEF_BIAS  = 4;

    // Total word width for a given exponent/fraction split
    function automatic int word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    localparam int DEF_W = word_w(DEF_EXP_W, DEF_MAN_W);

    // Field slices of the default word
    localparam int DEF_SIGN_BIT = DEF_W - 1;
    localparam int DEF_EXP_MSB  = DEF_W - 2;
    localparam int DEF_EXP_LSB  = DEF_MAN_W;
    localparam int DEF_MAN_MSB  = DEF_MAN_W - 1;

    // Rounding modes
    localparam bit RND_TRUNC = 1'b0;
    localparam bit RND_RNE   = 1'b1;

    // Overflow handling modes
    localparam bit SAT_ZERO  = 1'b0;
    localparam bit SAT_MAX   = 1'b1;

endpackage : float_pkg
`default_nettype wire

// File: rtl/float_round_norm.sv
`default_nettype none
// ============================================================================
//  Module      : float_round_norm
//  Description : Combinational normalise / round / pack stage for minifloat
//                results. Takes the raw 2*MAN_W+2 bit mantissa product, the
//                biased exponent sum, sign and zero flag and produces the
//                packed word plus overflow / underflow flags.
//  Ports       : prod      in  raw mantissa product {1.f1}*{1.f2}
//                esum      in  signed biased exponent sum (EXP_W+2 bits)
//                sign      in  result sign
//                zero      in  either operand was zero
//                num       out packed result word
//                overflow  out exponent above maximum
//                underflow out nonzero result with negative exponent
//  Revision    : 1.0 - initial release
// ============================================================================
module float_round_norm
    import float_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MAN_W  = DEF_MAN_W,
    parameter bit SAT_EN = SAT_MAX,
    parameter bit RND_EN = RND_RNE
) (
    input  logic [2*MAN_W+1:0]          prod,
    input  logic signed [EXP_W+1:0]     esum,
    input  logic                        sign,
    input  logic                        zero,
    output logic [EXP_W+MAN_W:0]        num,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int M  = MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int W  = word_w(EXP_W, MAN_W);
    // One extra bit over the exponent sum so the +1 from normalisation and
    // the +1 from rounding carry can never wrap.
    localparam int XW = EXP_W + 3;
    localparam logic [XW-2:0] c_EXP_MAX = (XW-1)'((1 << EXP_W) - 1);

    logic            w_msb;
    logic [PW-2:0]   w_norm;
    logic [M-1:0]    w_frac;
    logic            w_guard;
    logic            w_sticky;
    logic            w_inc;
    logic [M:0]      w_frac_sum;
    logic [XW-1:0]   w_exp_n;
    logic [XW-1:0]   w_exp_r;

    // Product is in [1,4): shift left by one when the top bit is clear so the
    // hidden one always sits at w_norm's (dropped) msb position.
    assign w_msb    = prod[PW-1];
    assign w_norm   = w_msb ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    assign w_frac   = w_norm[2*M:M+1];
    assign w_guard  = w_norm[M];
    assign w_sticky = |w_norm[M-1:0];

    assign w_inc      = (RND_EN == RND_RNE) & w_guard & (w_sticky | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + {{M{1'b0}}, w_inc};

    // A carry out of the fraction leaves the fraction bits all zero, which is
    // exactly 1.0 at the next exponent.
    assign w_exp_n = {esum[EXP_W+1], esum} + {{(XW-1){1'b0}}, w_msb};
    assign w_exp_r = w_exp_n + {{(XW-1){1'b0}}, w_frac_sum[M]};

    assign overflow  = ~zero & ~w_exp_r[XW-1] & (w_exp_r[XW-2:0] > c_EXP_MAX);
    assign underflow = ~zero &  w_exp_r[XW-1];

    always_comb begin
        num = {sign, w_exp_r[EXP_W-1:0], w_frac_sum[M-1:0]};
        if (zero) begin
            num = '0;
        end else if (overflow) begin
            num = (SAT_EN == SAT_MAX) ? {sign, {(W-1){1'b1}}} : '0;
        end else if (underflow) begin
            num = '0;
        end
    end

endmodule : float_round_norm
`default_nettype wire

// File: rtl/float_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : float_mult_pipe
//  Description : Three-stage pipelined minifloat multiplier with valid/ready
//                flow control, round-to-nearest-even and saturation.
//                S1 registers operand fields, S2 forms the mantissa product,
//                S3 normalises/rounds/packs into the output register.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                iValid, oReady  input handshake
//                iNum1, iNum2    operands {s, e, f}
//                oValid, iReady  output handshake
//                oNum            product
//                overflow        result exponent too large (with oValid)
//                underflow       nonzero result exponent < 0 (with oValid)
//  Revision    : 1.0 - initial release
// ============================================================================
module float_mult_pipe
    import float_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MAN_W  = DEF_MAN_W,
    parameter int BIAS   = DEF_BIAS,
    parameter bit SAT_EN = SAT_MAX,
    parameter bit RND_EN = RND_RNE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic [EXP_W+MAN_W:0]         iNum1,
    input  logic [EXP_W+MAN_W:0]         iNum2,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [EXP_W+MAN_W:0]         oNum,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int W  = word_w(EXP_W, MAN_W);
    localparam int M  = MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] c_BIAS = EW'(BIAS);

    // Whole pipeline moves as one: it only holds when the output register is
    // occupied and downstream refuses it.
    logic w_adv;
    assign w_adv  = ~oValid | iReady;
    assign oReady = w_adv;

    // ---------------- S1: operand fields ----------------
    logic                 r1_valid;
    logic                 r1_zero;
    logic                 r1_sign;
    logic signed [EW-1:0] r1_esum;
    logic [M:0]           r1_man_a;
    logic [M:0]           r1_man_b;

    logic [EW-1:0] w_esum;
    assign w_esum = {2'b00, iNum1[W-2:M]} + {2'b00, iNum2[W-2:M]} - c_BIAS;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_zero  <= 1'b0;
            r1_sign  <= 1'b0;
            r1_esum  <= '0;
            r1_man_a <= '0;
            r1_man_b <= '0;
        end else if (w_adv) begin
            r1_valid <= iValid;
            r1_zero  <= (iNum1[W-2:0] == '0) | (iNum2[W-2:0] == '0);
            r1_sign  <= iNum1[W-1] ^ iNum2[W-1];
            r1_esum  <= w_esum;
            r1_man_a <= {1'b1, iNum1[M-1:0]};
            r1_man_b <= {1'b1, iNum2[M-1:0]};
        end
    end

    // ---------------- S2: mantissa product ----------------
    logic                 r2_valid;
    logic                 r2_zero;
    logic                 r2_sign;
    logic signed [EW-1:0] r2_esum;
    logic [PW-1:0]        r2_prod;

    logic [PW-1:0] w_prod;
    assign w_prod = PW'(r1_man_a) * PW'(r1_man_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_zero  <= 1'b0;
            r2_sign  <= 1'b0;
            r2_esum  <= '0;
            r2_prod  <= '0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_zero  <= r1_zero;
            r2_sign  <= r1_sign;
            r2_esum  <= r1_esum;
            r2_prod  <= w_prod;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [W-1:0] w_num;
    logic         w_ovf;
    logic         w_unf;

    float_round_norm #(
        .EXP_W  (EXP_W),
        .MAN_W  (MAN_W),
        .SAT_EN (SAT_EN),
        .RND_EN (RND_EN)
    ) u_round_norm (
        .prod      (r2_prod),
        .esum      (r2_esum),
        .sign      (r2_sign),
        .zero      (r2_zero),
        .num       (w_num),
        .overflow  (w_ovf),
        .underflow (w_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            oValid    <= 1'b0;
            oNum      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (w_adv) begin
            oValid    <= r2_valid;
            oNum      <= w_num;
            overflow  <= w_ovf & r2_valid;
            underflow <= w_unf & r2_valid;
        end
    end

endmodule : float_mult_pipe
`default_nettype wire

// File: tb/tb_float_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_mult_pipe
//  Description : Scoreboard bench for float_mult_pipe. Two instances share
//                stimulus: u_dut0 with rounding + saturation, u_dut1 with
//                truncation + overflow-to-zero. Expected results are queued at
//                input acceptance and popped when each DUT hands a result out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_mult_pipe;
    import float_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iValid = 1'b0;
    logic       iReady = 1'b1;
    logic [7:0] iNum1 = '0;
    logic [7:0] iNum2 = '0;

    logic       oReady0, oValid0, ovf0, unf0;
    logic [7:0] oNum0;
    logic       oReady1, oValid1, ovf1, unf1;
    logic [7:0] oNum1;

    always #5 clk = ~clk;

    float_mult_pipe #(.EXP_W(3), .MAN_W(4), .BIAS(4), .SAT_EN(1'b1), .RND_EN(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .iValid(iValid), .oReady(oReady0),
        .iNum1(iNum1), .iNum2(iNum2), .oValid(oValid0), .iReady(iReady),
        .oNum(oNum0), .overflow(ovf0), .underflow(unf0)
    );

    float_mult_pipe #(.EXP_W(3), .MAN_W(4), .BIAS(4), .SAT_EN(1'b0), .RND_EN(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .iValid(iValid), .oReady(oReady1),
        .iNum1(iNum1), .iNum2(iNum2), .oValid(oValid1), .iReady(iReady),
        .oNum(oNum1), .overflow(ovf1), .underflow(unf1)
    );

    typedef struct {
        logic [9:0] exp;      // {overflow, underflow, num}
        int         t;
        bit         chk_lat;
    } sb_t;

    sb_t        q0[$];
    sb_t        q1[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    bit         dir_en = 1'b0;
    logic [9:0] dir_exp0 = '0;
    logic [9:0] dir_exp1 = '0;
    bit         lat_chk = 1'b0;
    bit         st[2];
    logic [9:0] held[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer product of the significands, rounded to MAN_W
    // fraction bits by remainder comparison.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input bit sat, input bit rnd);
        int ea, eb, p, n, sh, q, rem, half, e;
        logic s;
        logic [7:0] r;
        s  = a[DEF_SIGN_BIT] ^ b[DEF_SIGN_BIT];
        if (a[DEF_EXP_MSB:0] == 0 || b[DEF_EXP_MSB:0] == 0) return 10'h000;
        ea = int'(a[DEF_EXP_MSB:DEF_EXP_LSB]);
        eb = int'(b[DEF_EXP_MSB:DEF_EXP_LSB]);
        p  = (16 + int'(a[DEF_MAN_MSB:0])) * (16 + int'(b[DEF_MAN_MSB:0]));
        n  = (p >= 512) ? 9 : 8;
        sh = n - 4;
        q  = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
        e = n + ea + eb - 4 - 8;
        if (q == 32) begin q = 16; e = e + 1; end
        if (e > 7) begin
            r = sat ? {s, 7'h7F} : 8'h00;
            return {2'b10, r};
        end
        if (e < 0) return 10'h100;
        r = {s, 3'(e), 4'(q - 16)};
        return {2'b00, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_dut(input int id, input logic ov, input logic ordy, input logic [9:0] act);
        sb_t e;
        int  sz;
        if (st[id] && ov) chk($sformatf("hold_stable%0d", id), 32'(act), 32'(held[id]));
        if (ov && !iReady) chk($sformatf("stall_oready%0d", id), 32'(ordy), 32'd0);
        if (ov && iReady) begin
            sz = (id == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result%0d: got %0h expected none", id, act);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("result%0d", id), 32'(act), 32'(e.exp));
                if (e.chk_lat) chk($sformatf("latency%0d", id), 32'(cyc - e.t), 32'd3);
            end
        end
        st[id]   = ov && !iReady;
        held[id] = act;
    endtask

    // Monitor / scoreboard: runs mid-cycle so handshakes seen here are the
    // ones the next rising edge will act on.
    initial begin
        sb_t e;
        st[0] = 1'b0; st[1] = 1'b0;
        held[0] = '0; held[1] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete();
                q1.delete();
                st[0] = 1'b0;
                st[1] = 1'b0;
            end else begin
                if (iValid && oReady0) begin
                    e.exp = dir_en ? dir_exp0 : model(iNum1, iNum2, 1'b1, 1'b1);
                    e.t = cyc; e.chk_lat = lat_chk;
                    q0.push_back(e);
                end
                if (iValid && oReady1) begin
                    e.exp = dir_en ? dir_exp1 : model(iNum1, iNum2, 1'b0, 1'b0);
                    e.t = cyc; e.chk_lat = lat_chk;
                    q1.push_back(e);
                end
                check_dut(0, oValid0, oReady0, {ovf0, unf0, oNum0});
                check_dut(1, oValid1, oReady1, {ovf1, unf1, oNum1});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit d,
                        input logic [9:0] e0, input logic [9:0] e1);
        int n;
        iValid = 1'b1; iNum1 = a; iNum2 = b;
        dir_en = d; dir_exp0 = e0; dir_exp1 = e1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!oReady0 && n < 200);
        if (!oReady0) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got oReady 0 expected 1");
        end
        @(posedge clk); #1;
        iValid = 1'b0;
        dir_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ovalid0", 32'(oValid0), 0);
        chk("rst_onum0",   32'(oNum0), 0);
        chk("rst_flags0",  32'({ovf0, unf0}), 0);
        chk("rst_ovalid1", 32'(oValid1), 0);
        chk("rst_flags1",  32'({ovf1, unf1, oNum1}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases, one at a time, latency checked
        lat_chk = 1'b1;
        send(8'h48, 8'h48, 1'b1, 10'h052, 10'h052); idle(4);
        send(8'hC8, 8'h40, 1'b1, 10'h0C8, 10'h0C8); idle(4);
        send(8'h00, 8'h7F, 1'b1, 10'h000, 10'h000); idle(4);
        send(8'h80, 8'hC8, 1'b1, 10'h000, 10'h000); idle(4);
        send(8'h47, 8'h47, 1'b1, 10'h051, 10'h050); idle(4);
        send(8'h7F, 8'h7F, 1'b1, 10'h27F, 10'h200); idle(4);
        send(8'hFF, 8'h7F, 1'b1, 10'h2FF, 10'h200); idle(4);
        send(8'h01, 8'h01, 1'b1, 10'h100, 10'h100); idle(4);
        lat_chk = 1'b0;

        // Six back-to-back pairs with a downstream stall in cycles 4..8
        fork
            begin
                for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), 1'b0, '0, '0);
            end
            begin
                idle(4); iReady = 1'b0;
                idle(5); iReady = 1'b1;
            end
        join
        idle(8);

        // Reset with data in flight and the output stalled
        iReady = 1'b0;
        for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 1'b0, '0, '0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        iReady = 1'b1;
        @(negedge clk);
        chk("midrst_ovalid0", 32'(oValid0), 0);
        chk("midrst_ovalid1", 32'(oValid1), 0);
        idle(10);

        // Randomised traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    idle($urandom_range(0, 2));
                    send(8'($urandom), 8'($urandom), 1'b0, '0, '0);
                end
            end
            begin
                for (int i = 0; i < 800; i++) begin
                    @(posedge clk); #1;
                    iReady = ($urandom_range(0, 3) != 0);
                end
                iReady = 1'b1;
            end
        join
        iReady = 1'b1;

        // Drain
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_float_mult_pipe
`default_nettype wire
